// File: rtl/pwm_phase_gen_pkg.sv
// Shared definitions for the PWM channel family: FSM encoding, default counter width
// and a small state helper reused by sibling channels.
package pwm_phase_gen_pkg;

    localparam int PWM_SIZE_DEFAULT = 13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ARM  = 2'b01,
        ST_RUN  = 2'b10
    } pwm_state_e;

    // The period counter only advances while the channel is armed or running.
    function automatic logic is_counting(input pwm_state_e st);
        return (st == ST_ARM) || (st == ST_RUN);
    endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// Free-running period counter with restart (sync) and end-of-period tick.
// Kept separate so several PWM channels can share one instance.
module pwm_period_counter
    import pwm_phase_gen_pkg::*;
#(
    parameter int SIZE = PWM_SIZE_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic            sync_in,
    output logic [SIZE-1:0] cnt,
    output logic            boundary,
    output logic            period_tick
);

    localparam logic [SIZE-1:0] CNT_MAX = {SIZE{1'b1}};
    localparam logic [SIZE-1:0] CNT_ONE = {{(SIZE-1){1'b0}}, 1'b1};

    logic [SIZE-1:0] cnt_r;
    logic [SIZE-1:0] cnt_next_s;
    logic            tick_r;

    // Next count: held at zero when not running, restarted by sync, else wraps naturally.
    always_comb begin
        cnt_next_s = cnt_r;
        if (!run) begin
            cnt_next_s = '0;
        end else if (sync_in) begin
            cnt_next_s = '0;
        end else begin
            cnt_next_s = cnt_r + CNT_ONE;
        end
    end

    // A sync landing on the last count still yields one restart, since both map to zero.
    assign boundary = run && ((cnt_r == CNT_MAX) || sync_in);

    // Counter and tick registers; the tick is pre-decoded so it is high exactly while cnt is at max.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_next_s;
            tick_r <= (cnt_next_s == CNT_MAX);
        end
    end

    assign cnt         = cnt_r;
    assign period_tick = tick_r;

endmodule

// File: rtl/pwm_phase_gen.sv
// Phase-shifted PWM channel: shadow/active offset and duty registers, modular compare
// against the shared period counter, and a registered gate-drive output.
module pwm_phase_gen
    import pwm_phase_gen_pkg::*;
#(
    parameter int SIZE = PWM_SIZE_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            sync_in,
    input  logic [SIZE-1:0] offset,
    input  logic [SIZE-1:0] duty,
    output logic            pwm_out,
    output logic [SIZE-1:0] cnt,
    output logic            period_tick,
    output logic            running
);

    pwm_state_e      state_r;
    pwm_state_e      state_next_s;
    logic            run_s;
    logic            boundary_s;
    logic [SIZE-1:0] cnt_s;
    logic [SIZE-1:0] off_sh_r;
    logic [SIZE-1:0] duty_sh_r;
    logic [SIZE-1:0] off_act_r;
    logic [SIZE-1:0] duty_act_r;
    logic [SIZE-1:0] phase_s;
    logic            hit_s;
    logic            pwm_r;
    logic            running_r;

    // Dropping en stops the counter on the same edge the FSM returns to IDLE.
    assign run_s = en && is_counting(state_r);

    pwm_period_counter #(
        .SIZE        (SIZE)
    ) u_counter (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run_s),
        .sync_in     (sync_in),
        .cnt         (cnt_s),
        .boundary    (boundary_s),
        .period_tick (period_tick)
    );

    // Next-state logic; en low wins over everything, including a coincident sync.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (en) begin
                    state_next_s = ST_ARM;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (!en) begin
                    state_next_s = ST_IDLE;
                end else if (boundary_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_ARM;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Unsigned modular distance from the rising edge; wraps pulses across the period end.
    assign phase_s = cnt_s - off_act_r;
    assign hit_s   = (phase_s < duty_act_r);

    // State, gate drive and running flag; gate is forced low on the edge that enters IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            pwm_r     <= 1'b0;
            running_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            pwm_r     <= en && (state_r == ST_RUN) && hit_s;
            running_r <= (state_next_s == ST_RUN);
        end
    end

    // Shadow registers track the inputs; active copies change only at a period boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_sh_r   <= '0;
            duty_sh_r  <= '0;
            off_act_r  <= '0;
            duty_act_r <= '0;
        end else begin
            off_sh_r  <= offset;
            duty_sh_r <= duty;
            if (boundary_s) begin
                off_act_r  <= off_sh_r;
                duty_act_r <= duty_sh_r;
            end
        end
    end

    assign pwm_out = pwm_r;
    assign cnt     = cnt_s;
    assign running = running_r;

endmodule

// File: tb/tb_pwm_phase_gen.sv
// Self-checking bench for pwm_phase_gen (SIZE=13): directed scenarios plus randomized
// traffic, all compared cycle by cycle against an arithmetic reference model.
module tb_pwm_phase_gen;

    localparam int SZ     = 13;
    localparam int P      = 8192;
    localparam int M_IDLE = 0;
    localparam int M_ARM  = 1;
    localparam int M_RUN  = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          en = 1'b0;
    logic          sync_in = 1'b0;
    logic [SZ-1:0] offset = '0;
    logic [SZ-1:0] duty = '0;
    logic          pwm_out;
    logic [SZ-1:0] cnt;
    logic          period_tick;
    logic          running;

    int checks = 0;
    int errors = 0;

    pwm_phase_gen #(.SIZE(SZ)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .sync_in     (sync_in),
        .offset      (offset),
        .duty        (duty),
        .pwm_out     (pwm_out),
        .cnt         (cnt),
        .period_tick (period_tick),
        .running     (running)
    );

    always #5 clk = ~clk;

    // Reference model: mode, period position and the latched offset/duty as plain integers.
    int m_mode = M_IDLE;
    int m_cnt = 0;
    int m_soff = 0;
    int m_sduty = 0;
    int m_aoff = 0;
    int m_aduty = 0;
    bit m_pwm = 1'b0;
    bit m_tick = 1'b0;
    bit m_run = 1'b0;

    bit live;
    bit restart;
    int nxt_cnt;
    int nxt_mode;
    bit nxt_pwm;

    always_comb begin
        live     = en && (m_mode != M_IDLE);
        restart  = live && ((m_cnt == P - 1) || sync_in);
        nxt_cnt  = !live ? 0 : (sync_in ? 0 : (m_cnt + 1) % P);
        if (!en)                               nxt_mode = M_IDLE;
        else if (m_mode == M_IDLE)             nxt_mode = M_ARM;
        else if (m_mode == M_ARM && restart)   nxt_mode = M_RUN;
        else                                   nxt_mode = m_mode;
        nxt_pwm  = en && (m_mode == M_RUN) && (((m_cnt - m_aoff + P) % P) < m_aduty);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= M_IDLE; m_cnt <= 0; m_soff <= 0; m_sduty <= 0;
            m_aoff <= 0; m_aduty <= 0; m_pwm <= 1'b0; m_tick <= 1'b0; m_run <= 1'b0;
        end else begin
            m_mode  <= nxt_mode;
            m_cnt   <= nxt_cnt;
            m_pwm   <= nxt_pwm;
            m_tick  <= (nxt_cnt == P - 1);
            m_run   <= (nxt_mode == M_RUN);
            m_soff  <= int'(offset);
            m_sduty <= int'(duty);
            if (restart) begin
                m_aoff  <= m_soff;
                m_aduty <= m_sduty;
            end
        end
    end

    logic [15:0] dut_vec;
    logic [15:0] exp_vec;
    assign dut_vec = {pwm_out, period_tick, running, cnt};
    assign exp_vec = {m_pwm, m_tick, m_run, SZ'(m_cnt)};

    task automatic test_reset();
        #1 rst_n = 1'b0;
        en = 1'b0; sync_in = 1'b0; offset = 13'd1234; duty = 13'd99;
        repeat (3) @(negedge clk);
        checks++;
        if (dut_vec !== 16'h0000) begin
            errors++; $display("FAIL reset_outputs got %h exp 0000", dut_vec);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sync_in = i[0];
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL lockstep_reset got %h exp %h at %0t", dut_vec, exp_vec, $time);
            end
        end
        sync_in = 1'b0;
        checks++;
        if (running !== 1'b0 || cnt !== 13'd0) begin
            errors++; $display("FAIL idle_ignores_sync got run=%b cnt=%0d exp run=0 cnt=0", running, cnt);
        end
    endtask

    task automatic test_basic();
        int n = 0, arm_hi = 0, hi = 0, first = -1, last = -1;
        en = 1'b1; offset = 13'd100; duty = 13'd200;
        @(negedge clk);
        while (running !== 1'b1 && n < 9000) begin
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL lockstep_basic_arm got %h exp %h at %0t", dut_vec, exp_vec, $time);
            end
            n++;
            if (pwm_out) arm_hi++;
            @(negedge clk);
        end
        checks++;
        if (n !== 8192) begin
            errors++; $display("FAIL basic_arm_length got %0d exp 8192", n);
        end
        checks++;
        if (arm_hi !== 0) begin
            errors++; $display("FAIL basic_arm_pwm_low got %0d high clocks exp 0", arm_hi);
        end
        repeat (P) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL lockstep_basic_run got %h exp %h at %0t", dut_vec, exp_vec, $time);
            end
            if (pwm_out) begin
                hi++;
                if (first < 0) first = int'(cnt);
                last = int'(cnt);
            end
        end
        checks++;
        if (hi !== 200 || first !== 101 || last !== 300) begin
            errors++; $display("FAIL basic_pulse got %0d clocks %0d..%0d exp 200 clocks 101..300", hi, first, last);
        end
    endtask

    task automatic test_wrap();
        int hi = 0;
        offset = 13'd8100; duty = 13'd200;
        @(negedge clk); sync_in = 1'b1;
        @(negedge clk); sync_in = 1'b0;
        repeat (P) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL lockstep_wrap got %h exp %h at %0t", dut_vec, exp_vec, $time);
            end
            if (pwm_out) hi++;
        end
        checks++;
        if (hi !== 200 || cnt !== 13'd0 || pwm_out !== 1'b1) begin
            errors++; $display("FAIL wrap_pulse got %0d clocks pwm@cnt%0d=%b exp 200 clocks pwm@cnt0=1", hi, cnt, pwm_out);
        end
        repeat (108) @(negedge clk);
        checks++;
        if (cnt !== 13'd108 || pwm_out !== 1'b1) begin
            errors++; $display("FAIL wrap_tail_high got cnt=%0d pwm=%b exp cnt=108 pwm=1", cnt, pwm_out);
        end
        @(negedge clk);
        checks++;
        if (cnt !== 13'd109 || pwm_out !== 1'b0) begin
            errors++; $display("FAIL wrap_tail_end got cnt=%0d pwm=%b exp cnt=109 pwm=0", cnt, pwm_out);
        end
    endtask

    task automatic test_mid_update();
        int h1 = 0, h2 = 0;
        offset = 13'd100; duty = 13'd200;
        @(negedge clk); sync_in = 1'b1;
        @(negedge clk); sync_in = 1'b0;
        for (int n = 1; n <= P + 400; n++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL lockstep_mid got %h exp %h at %0t", dut_vec, exp_vec, $time);
            end
            if (pwm_out) begin
                if (n < P) h1++;
                else h2++;
            end
            if (n == 4000) duty = 13'd50;
        end
        checks++;
        if (h1 !== 200 || h2 !== 50) begin
            errors++; $display("FAIL mid_update got %0d then %0d clocks exp 200 then 50", h1, h2);
        end
    endtask

    task automatic test_duty_limits();
        int hi = 0, lo = 0, ticks = 0;
        duty = 13'd0; offset = 13'($urandom_range(0, P - 1));
        @(negedge clk); sync_in = 1'b1;
        @(negedge clk); sync_in = 1'b0;
        repeat (P) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL lockstep_duty0 got %h exp %h at %0t", dut_vec, exp_vec, $time);
            end
            if (pwm_out) hi++;
        end
        checks++;
        if (hi !== 0) begin
            errors++; $display("FAIL duty_zero got %0d high clocks exp 0", hi);
        end
        duty = 13'd8191; offset = 13'($urandom_range(0, P - 1));
        @(negedge clk); sync_in = 1'b1;
        @(negedge clk); sync_in = 1'b0;
        repeat (P) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL lockstep_dutymax got %h exp %h at %0t", dut_vec, exp_vec, $time);
            end
            if (!pwm_out) lo++;
            if (period_tick) ticks++;
        end
        checks++;
        if (lo !== 1 || ticks !== 1) begin
            errors++; $display("FAIL duty_max got %0d low clocks %0d ticks exp 1 low 1 tick", lo, ticks);
        end
    endtask

    task automatic test_sync();
        int n = 0, hi = 0, ticks = 0;
        while (cnt !== 13'd2999 && n < 9000) begin
            @(negedge clk); n++;
        end
        checks++;
        if (cnt !== 13'd2999) begin
            errors++; $display("FAIL sync_wait_timeout got cnt=%0d exp 2999", cnt);
        end
        offset = 13'd500; duty = 13'd77;
        @(negedge clk); sync_in = 1'b1;
        if (period_tick) ticks++;
        @(negedge clk); sync_in = 1'b0;
        checks++;
        if (cnt !== 13'd0 || period_tick !== 1'b0) begin
            errors++; $display("FAIL sync_restart got cnt=%0d tick=%b exp cnt=0 tick=0", cnt, period_tick);
        end
        repeat (1000) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL lockstep_sync got %h exp %h at %0t", dut_vec, exp_vec, $time);
            end
            if (pwm_out) hi++;
            if (period_tick) ticks++;
        end
        checks++;
        if (hi !== 77 || ticks !== 0) begin
            errors++; $display("FAIL sync_reload got %0d clocks %0d ticks exp 77 clocks 0 ticks", hi, ticks);
        end
        n = 0;
        while (cnt !== 13'd8191 && n < 9000) begin
            @(negedge clk); n++;
        end
        sync_in = 1'b1;
        @(negedge clk); sync_in = 1'b0;
        checks++;
        if (cnt !== 13'd0 || period_tick !== 1'b0) begin
            errors++; $display("FAIL sync_at_max got cnt=%0d tick=%b exp cnt=0 tick=0", cnt, period_tick);
        end
        @(negedge clk);
        checks++;
        if (dut_vec !== exp_vec || cnt !== 13'd1) begin
            errors++; $display("FAIL sync_at_max_next got %h exp %h", dut_vec, exp_vec);
        end
    endtask

    task automatic test_sync_en_fall();
        en = 1'b0; sync_in = 1'b1;
        @(negedge clk);
        checks++;
        if (running !== 1'b0 || cnt !== 13'd0 || pwm_out !== 1'b0) begin
            errors++; $display("FAIL sync_en_fall got run=%b cnt=%0d pwm=%b exp 0 0 0", running, cnt, pwm_out);
        end
        for (int i = 0; i < 4; i++) begin
            sync_in = ~sync_in;
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec || cnt !== 13'd0) begin
                errors++; $display("FAIL lockstep_idle got %h exp %h at %0t", dut_vec, exp_vec, $time);
            end
        end
        sync_in = 1'b0;
    endtask

    task automatic test_async_reset();
        int n = 0, hi = 0;
        en = 1'b1; offset = 13'd0; duty = 13'd4000;
        @(negedge clk); sync_in = 1'b1;
        @(negedge clk); sync_in = 1'b0;
        while (pwm_out !== 1'b1 && n < 100) begin
            @(negedge clk); n++;
        end
        checks++;
        if (pwm_out !== 1'b1) begin
            errors++; $display("FAIL async_setup got pwm=%b exp 1", pwm_out);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (pwm_out !== 1'b0 || running !== 1'b0 || cnt !== 13'd0) begin
            errors++; $display("FAIL async_reset got pwm=%b run=%b cnt=%0d exp 0 0 0", pwm_out, running, cnt);
        end
        @(negedge clk); rst_n = 1'b1;
        n = 0;
        @(negedge clk);
        while (running !== 1'b1 && n < 9000) begin
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL lockstep_rearm got %h exp %h at %0t", dut_vec, exp_vec, $time);
            end
            n++;
            if (pwm_out) hi++;
            @(negedge clk);
        end
        checks++;
        if (n !== 8192 || hi !== 0) begin
            errors++; $display("FAIL rearm_after_reset got %0d arm clocks %0d high exp 8192 arm 0 high", n, hi);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL lockstep_random got %h exp %h at %0t", dut_vec, exp_vec, $time);
            end
            if ($urandom_range(0, 49) == 0) offset = 13'($urandom_range(0, P - 1));
            case ($urandom_range(0, 59))
                0:       duty = 13'd0;
                1:       duty = 13'd8191;
                2, 3, 4: duty = 13'($urandom_range(0, P - 1));
                default: duty = duty;
            endcase
            sync_in = ($urandom_range(0, 299) == 0);
            en = ($urandom_range(0, 1999) != 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_mid_update();
        test_duty_limits();
        test_sync();
        test_sync_en_fall();
        test_async_reset();
        test_random();
        sync_in = 1'b0;
        en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_phase_gen.md
PWM_PHASE_GEN -- requirements
Module: pwm_phase_gen

Interface
REQ-001 SIZE, default 13, sets the counter, offset and duty width; the period is 2**SIZE clocks.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 en  input  1  run request; high runs the generator, low returns it to IDLE.
REQ-005 sync_in  input  1  single-cycle pulse that restarts the period, for phase alignment across channels.
REQ-006 offset  input  SIZE  requested rising-edge position within the period.
REQ-007 duty  input  SIZE  requested high time in clocks.
REQ-008 pwm_out  output  1  registered gate drive.
REQ-009 cnt  output  SIZE  current period counter value.
REQ-010 period_tick  output  1  one-cycle pulse, asserted while cnt = 2**SIZE-1.
REQ-011 running  output  1  high only in the RUN state.

Function
REQ-012 The counter SHALL increment by 1 modulo 2**SIZE every clock in the ARM and RUN states, and SHALL hold 0 in IDLE.
REQ-013 The shadow registers SHALL capture offset and duty every clock.
REQ-014 The active registers SHALL load from the shadow registers only when cnt = 2**SIZE-1 or sync_in = 1 (period boundary), so no mid-period glitch can occur.
REQ-015 The compare term SHALL be hit = ((cnt - off_act) mod 2**SIZE) < duty_act, evaluated as an unsigned SIZE-bit subtraction.
REQ-016 Because of REQ-015, a pulse with off_act + duty_act > 2**SIZE SHALL wrap past the period boundary into counts 0 onward.
REQ-017 pwm_out SHALL equal the registered value of (hit AND state = RUN), giving 1 clock of latency from cnt.
REQ-018 duty_act = 0 SHALL produce a constantly low output.
REQ-019 duty_act = 2**SIZE-1 SHALL produce exactly one low clock per period.
REQ-020 The state machine SHALL have three states: IDLE, ARM and RUN.
REQ-021 IDLE -> ARM when en = 1.
REQ-022 ARM -> RUN at the first period boundary; the active registers load on that same edge.
REQ-023 Any state -> IDLE on the clock after en falls.
REQ-024 On entry to IDLE, pwm_out SHALL be low on that same edge and the counter SHALL clear.
REQ-025 sync_in in ARM or RUN SHALL force cnt to 0 on the next clock and load the active registers; period_tick SHALL NOT fire for the truncated period.
REQ-026 sync_in in IDLE SHALL be ignored.
REQ-027 If sync_in and cnt = 2**SIZE-1 coincide, the result SHALL be a single reload and a single tick, with cnt -> 0.
REQ-028 If en falls and sync_in coincide, en falling SHALL take priority.

Reset
REQ-029 While rst_n = 0, the block SHALL hold: state = IDLE; cnt, shadow registers and active registers = 0; pwm_out, period_tick and running = 0.
REQ-030 Reset assertion mid-pulse SHALL drive pwm_out low immediately, without waiting for clk.
REQ-031 After rst_n deasserts, the first state change SHALL occur on the first clk edge with en = 1.

Structure
REQ-032 The state encoding (IDLE/ARM/RUN) and the default SIZE constant SHALL live in a shared package for reuse by sibling PWM channels.
REQ-033 The counter plus its boundary/tick logic SHALL be one sub-module, pwm_period_counter, so several channels can share a single instance.
REQ-034 The compare and output register SHALL remain in pwm_phase_gen.

Verification (SIZE=13)
REQ-035 Basic pulse: offset=100, duty=200, en=1 -> the first period is ARM with pwm_out low; in RUN, pwm_out is high for cnt = 101..300 of each period (one-clock lag), 200 clocks.
REQ-036 Wrap-around pulse: offset=8100, duty=200 -> pwm_out is high from cnt 8101 through 8191 and 0 through 108, 200 clocks contiguous across the boundary.
REQ-037 Mid-period update: duty changed 200 -> 50 at cnt=4000 -> the current period keeps the 200-clock pulse; the next period gives 50 clocks.
REQ-038 Duty limits: duty=0 -> pwm_out never high; duty=8191 -> exactly one low clock per period, with period_tick every 8192 clocks.
REQ-039 sync_in at cnt=3000 -> cnt=0 on the next clock, no period_tick for that period, new values loaded; sync_in together with en falling -> state = IDLE and cnt = 0.
REQ-040 rst_n pulsed low while pwm_out=1 -> pwm_out falls asynchronously; after release with en=1 -> the block passes through ARM for one full period before any pulse.
